// File: rtl/pipe_pkg.sv
// Shared pipeline bundle types, widths and per-stage side-effect masks.
// Stage registers import this to size their control/data bundles.
package pipe_pkg;

    // ID/EXE control: side effects are branch, jump, mem_read/write, reg_write
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] rsvd;
    } id_exe_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic        rsvd;
    } id_exe_data_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       reg_write;
        logic [1:0] wb_sel;
    } exe_mem_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  rd;
    } exe_mem_data_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wb_sel;
    } mem_wb_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] load_data;
        logic [4:0]  rd;
    } mem_wb_data_t;

    localparam int ID_EXE_CTRL_W  = $bits(id_exe_ctrl_t);
    localparam int ID_EXE_DATA_W  = $bits(id_exe_data_t);
    localparam int EXE_MEM_CTRL_W = $bits(exe_mem_ctrl_t);
    localparam int EXE_MEM_DATA_W = $bits(exe_mem_data_t);
    localparam int MEM_WB_CTRL_W  = $bits(mem_wb_ctrl_t);
    localparam int MEM_WB_DATA_W  = $bits(mem_wb_data_t);

    localparam logic [ID_EXE_CTRL_W-1:0]  ID_EXE_KILL_MASK  = 16'h0790;
    localparam logic [EXE_MEM_CTRL_W-1:0] EXE_MEM_KILL_MASK = 8'hC4;
    localparam logic [MEM_WB_CTRL_W-1:0]  MEM_WB_KILL_MASK  = 3'b100;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: valid + ctrl + data.
// kill squashes (masked ctrl zeroed), load stores, clr only drops valid.
module pipe_slot #(
    parameter int                 CTRL_W    = 16,
    parameter int                 DATA_W    = 128,
    parameter logic [CTRL_W-1:0]  KILL_MASK = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              kill_i,
    input  logic              clr_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next state: kill beats load beats clear; a bubble load masks ctrl
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (kill_i) begin
            valid_d = 1'b0;
            ctrl_d  = ctrl_q & ~KILL_MASK;
        end else if (load_i) begin
            valid_d = valid_i;
            ctrl_d  = valid_i ? ctrl_i : (ctrl_i & ~KILL_MASK);
            data_d  = data_i;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with skid slot, kill/flush and
// a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 CTRL_W    = ID_EXE_CTRL_W,
    parameter int                 DATA_W    = ID_EXE_DATA_W,
    parameter logic [CTRL_W-1:0]  KILL_MASK = '1,
    parameter bit                 SKID_EN   = 1'b1,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              kill_in,
    input  logic              flush_all,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic              acc, drn, main_free;
    logic              main_v;
    logic [CTRL_W-1:0] main_c;
    logic [DATA_W-1:0] main_dt;
    logic              skid_v;
    logic [CTRL_W-1:0] skid_c;
    logic [DATA_W-1:0] skid_dt;

    logic              main_ld, main_vin, main_clr;
    logic [CTRL_W-1:0] main_cin;
    logic [DATA_W-1:0] main_din;
    logic              skid_ld, skid_clr;
    logic              skid_v_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign acc       = in_valid && in_ready;
    assign drn       = main_v && out_ready;
    assign main_free = !main_v || drn;

    // Slot steering: skid drains into main first; bubbles never enter skid
    always_comb begin
        main_ld  = 1'b0;
        main_vin = 1'b0;
        main_cin = in_ctrl;
        main_din = in_data;
        main_clr = 1'b0;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (!flush_all) begin
            if (main_free) begin
                if (skid_v) begin
                    main_ld  = 1'b1;
                    main_vin = 1'b1;
                    main_cin = skid_c;
                    main_din = skid_dt;
                    if (acc && !kill_in) begin
                        skid_ld = 1'b1;
                    end else begin
                        skid_clr = 1'b1;
                    end
                end else if (acc) begin
                    main_ld  = 1'b1;
                    main_vin = !kill_in;
                end else if (drn) begin
                    main_clr = 1'b1;
                end
            end else if (acc && !kill_in) begin
                skid_ld = 1'b1;
            end
        end
    end

    pipe_slot #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .KILL_MASK (KILL_MASK)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_ld),
        .valid_i (main_vin),
        .ctrl_i  (main_cin),
        .data_i  (main_din),
        .kill_i  (flush_all),
        .clr_i   (main_clr),
        .valid_o (main_v),
        .ctrl_o  (main_c),
        .data_o  (main_dt)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic in_ready_q;

            pipe_slot #(
                .CTRL_W    (CTRL_W),
                .DATA_W    (DATA_W),
                .KILL_MASK (KILL_MASK)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (skid_ld),
                .valid_i (1'b1),
                .ctrl_i  (in_ctrl),
                .data_i  (in_data),
                .kill_i  (flush_all),
                .clr_i   (skid_clr),
                .valid_o (skid_v),
                .ctrl_o  (skid_c),
                .data_o  (skid_dt)
            );

            // Registered ready: mirrors the skid slot's next emptiness
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= !skid_v_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_v   = 1'b0;
            assign skid_c   = '0;
            assign skid_dt  = '0;
            assign in_ready = out_ready || !main_v;
        end
    endgenerate

    assign skid_v_d = flush_all ? 1'b0 :
                      skid_ld   ? 1'b1 :
                      skid_clr  ? 1'b0 : skid_v;

    // Saturating stall counter; clear has priority
    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr) begin
            cnt_d = '0;
        end else if (main_v && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stall counter storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = main_v;
    assign out_ctrl  = main_c;
    assign out_data  = main_dt;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stream, skid, kill, flush,
// async reset and stall counter saturation.
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 32;
    localparam int NW = 4;
    localparam logic [CW-1:0] MASK = 16'h00F0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          kill_in = 1'b0;
    logic          flush_all = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;
    logic          stall_clr = 1'b0;

    int tests = 0;
    int errs  = 0;
    logic [CW+DW-1:0] sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W    (CW),
        .DATA_W    (DW),
        .KILL_MASK (MASK),
        .SKID_EN   (1'b1),
        .CNT_W     (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .kill_in   (kill_in),
        .flush_all (flush_all),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every drained beat must match the oldest expected one
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                logic [CW+DW-1:0] e;
                e = sb.pop_front();
                chk("sb_ctrl", 64'(out_ctrl), 64'(e[CW+DW-1:DW]));
                chk("sb_data", 64'(out_data), 64'(e[DW-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] tbl [3];
        tbl[0] = 16'h00A1;
        tbl[1] = 16'h00B2;
        tbl[2] = 16'h00C3;

        // Reset state
        #3;
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("rdy_after_rst", 64'(in_ready), 64'd1);

        // Stream A, B, C back-to-back
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_ctrl  = tbl[i];
            in_data  = 32'h1000 + i;
            sb.push_back({tbl[i], 32'h1000 + i});
            cyc();
            chk("strm_vld", 64'(out_valid), 64'd1);
            chk("strm_ctrl", 64'(out_ctrl), 64'(tbl[i]));
            chk("strm_rdy", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        cyc();
        chk("strm_empty", 64'(out_valid), 64'd0);

        // Back-pressure: A in main, B to skid, C held upstream
        in_valid = 1'b1;
        in_ctrl  = tbl[0];
        in_data  = 32'h2000;
        sb.push_back({tbl[0], 32'h2000});
        cyc();
        out_ready = 1'b0;
        in_ctrl   = tbl[1];
        in_data   = 32'h2001;
        sb.push_back({tbl[1], 32'h2001});
        cyc();
        chk("skid_rdy0", 64'(in_ready), 64'd0);
        in_ctrl = tbl[2];
        in_data = 32'h2002;
        sb.push_back({tbl[2], 32'h2002});
        cyc();
        cyc();
        chk("bp_hold", 64'(out_ctrl), 64'(tbl[0]));
        chk("bp_cnt", 64'(stall_cnt), 64'd3);
        out_ready = 1'b1;
        cyc();
        chk("bp_b", 64'(out_ctrl), 64'(tbl[1]));
        chk("bp_rdy1", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        chk("bp_c", 64'(out_ctrl), 64'(tbl[2]));
        cyc();
        chk("bp_cnt_end", 64'(stall_cnt), 64'd3);

        // Kill: bubble with masked ctrl, data kept
        in_valid = 1'b1;
        kill_in  = 1'b1;
        in_ctrl  = 16'hFFFF;
        in_data  = 32'h1234_5678;
        cyc();
        in_valid = 1'b0;
        kill_in  = 1'b0;
        chk("kill_vld", 64'(out_valid), 64'd0);
        chk("kill_ctrl", 64'(out_ctrl), 64'hFF0F);
        chk("kill_data", 64'(out_data), 64'h1234_5678);

        // Flush with both slots full and D offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 16'h12A1;
        in_data   = 32'h3000;
        cyc();
        in_ctrl = 16'h12B2;
        in_data = 32'h3001;
        cyc();
        chk("fl_full", 64'(in_ready), 64'd0);
        flush_all = 1'b1;
        in_ctrl   = 16'h00DD;
        in_data   = 32'h3DDD;
        cyc();
        flush_all = 1'b0;
        in_valid  = 1'b0;
        chk("fl_vld", 64'(out_valid), 64'd0);
        chk("fl_rdy", 64'(in_ready), 64'd1);
        chk("fl_ctrl", 64'(out_ctrl), 64'h1201);
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("fl_noD", 64'(out_valid), 64'd0);

        // Async reset mid-transfer with both slots full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 16'h0051;
        in_data   = 32'h4000;
        cyc();
        in_ctrl = 16'h0052;
        in_data = 32'h4001;
        cyc();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld", 64'(out_valid), 64'd0);
        chk("ar_ctrl", 64'(out_ctrl), 64'd0);
        chk("ar_data", 64'(out_data), 64'd0);
        chk("ar_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("ar_rdy", 64'(in_ready), 64'd1);
        chk("ar_vld2", 64'(out_valid), 64'd0);

        // Stall counter saturation and clear
        in_valid = 1'b1;
        in_ctrl  = 16'h0077;
        in_data  = 32'h5000;
        sb.push_back({16'h0077, 32'h5000});
        cyc();
        in_valid = 1'b0;
        repeat (16) cyc();
        chk("sat_max", 64'(stall_cnt), 64'hF);
        repeat (2) cyc();
        chk("sat_hold", 64'(stall_cnt), 64'hF);
        stall_clr = 1'b1;
        cyc();
        stall_clr = 1'b0;
        chk("sat_clr", 64'(stall_cnt), 64'd0);
        cyc();
        chk("sat_inc", 64'(stall_cnt), 64'd1);
        out_ready = 1'b1;
        cyc();
        chk("sat_drain", 64'(out_valid), 64'd0);
        cyc();
        chk("sb_left", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
